// File: rtl/consumer_transaction_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : consumer_transaction_pkg
//  Description : Shared types for the consumer read-transaction path: default
//                address/ID/data widths, tracker entry state and entry record.
//  Revision    : 1.0 - configurable-width tracker types
// ============================================================================
package consumer_transaction_pkg;

    // Default widths of the original fixed transaction types
    localparam int DEFAULT_ADDR_WIDTH = 64;
    localparam int DEFAULT_ID_WIDTH   = 4;
    localparam int DEFAULT_DATA_WIDTH = 64;

    typedef logic [DEFAULT_ADDR_WIDTH-1:0] addr_t;
    typedef logic [DEFAULT_ID_WIDTH-1:0]   id_t;
    typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;

    // Lifecycle of one tracker slot: allocated on issue, filled by response,
    // released on in-order retirement
    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_ISSUED = 2'd1,
        ST_DONE   = 2'd2
    } entry_state_e;

    // Entry record at the default widths
    typedef struct packed {
        entry_state_e state;
        addr_t        addr;
        data_t        data;
    } entry_t;

endpackage
`default_nettype wire

// File: rtl/consumer_txn_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : consumer_txn_ptr
//  Description : Wrapping index counter, modulus NUM_IDS, advancing on i_inc.
//  Revision    : 1.0 - initial
// ============================================================================
module consumer_txn_ptr #(
    parameter int ID_WIDTH = 4,
    parameter int NUM_IDS  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_inc,
    output logic [ID_WIDTH-1:0] o_idx
);

    localparam logic [ID_WIDTH-1:0] c_LAST_IDX = ID_WIDTH'(NUM_IDS - 1);

    logic [ID_WIDTH-1:0] r_idx;

    // Advance the index, wrapping from the last slot back to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (i_inc) begin
            if (r_idx == c_LAST_IDX) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + ID_WIDTH'(1);
            end
        end
    end

    assign o_idx = r_idx;

endmodule
`default_nettype wire

// File: rtl/consumer_txn_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : consumer_txn_tracker
//  Description : Outstanding read tracker. Allocates IDs in order, accepts
//                out-of-order responses by ID, retires data in request order.
//  Revision    : 1.0 - configurable width/depth tracker
// ============================================================================
module consumer_txn_tracker
    import consumer_transaction_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int NUM_IDS    = 16,
    parameter int CNT_WIDTH  = $clog2(NUM_IDS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    output logic [ID_WIDTH-1:0]   mem_req_id_o,
    input  logic                  mem_resp_valid_i,
    input  logic [ID_WIDTH-1:0]   mem_resp_id_i,
    input  logic [DATA_WIDTH-1:0] mem_resp_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ADDR_WIDTH-1:0] out_addr_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [CNT_WIDTH-1:0]  outstanding_o,
    output logic                  err_o
);

    entry_state_e          r_state [NUM_IDS];
    logic [ADDR_WIDTH-1:0] r_addr  [NUM_IDS];
    logic [DATA_WIDTH-1:0] r_data  [NUM_IDS];
    logic [CNT_WIDTH-1:0]  r_outstanding;
    logic                  r_err;

    logic [ID_WIDTH-1:0]   w_alloc_ptr;
    logic [ID_WIDTH-1:0]   w_ret_ptr;
    entry_state_e          w_alloc_state;
    entry_state_e          w_ret_state;
    entry_state_e          w_resp_state;
    logic [ADDR_WIDTH-1:0] w_ret_addr;
    logic [DATA_WIDTH-1:0] w_ret_data;
    logic                  w_slot_free;
    logic                  w_fire;
    logic                  w_retire;
    logic                  w_resp_ok;
    logic                  w_resp_bad;

    consumer_txn_ptr #(
        .ID_WIDTH (ID_WIDTH),
        .NUM_IDS  (NUM_IDS)
    ) u_alloc_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_fire),
        .o_idx (w_alloc_ptr)
    );

    consumer_txn_ptr #(
        .ID_WIDTH (ID_WIDTH),
        .NUM_IDS  (NUM_IDS)
    ) u_ret_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_retire),
        .o_idx (w_ret_ptr)
    );

    // Slot lookups by comparison so an out-of-range response ID selects
    // nothing and reads back as FREE (which flags it as an error)
    always_comb begin
        w_alloc_state = ST_FREE;
        w_ret_state   = ST_FREE;
        w_resp_state  = ST_FREE;
        w_ret_addr    = '0;
        w_ret_data    = '0;
        for (int i = 0; i < NUM_IDS; i++) begin
            if (w_alloc_ptr == ID_WIDTH'(i)) begin
                w_alloc_state = r_state[i];
            end
            if (w_ret_ptr == ID_WIDTH'(i)) begin
                w_ret_state = r_state[i];
                w_ret_addr  = r_addr[i];
                w_ret_data  = r_data[i];
            end
            if (mem_resp_id_i == ID_WIDTH'(i)) begin
                w_resp_state = r_state[i];
            end
        end
    end

    // Issue, response-accept and retire decisions; rst_n gates issue so
    // nothing is offered while the tracker is held in reset
    always_comb begin
        w_slot_free = rst_n & (w_alloc_state == ST_FREE);
        w_fire      = req_valid_i & mem_req_ready_i & w_slot_free;
        w_resp_ok   = mem_resp_valid_i & (w_resp_state == ST_ISSUED);
        w_resp_bad  = mem_resp_valid_i & (w_resp_state != ST_ISSUED);
        w_retire    = (w_ret_state == ST_DONE) & out_ready_i;
    end

    assign mem_req_valid_o = req_valid_i & w_slot_free;
    assign req_ready_o     = mem_req_ready_i & w_slot_free;
    assign mem_req_addr_o  = req_addr_i;
    assign mem_req_id_o    = w_alloc_ptr;
    assign out_valid_o     = (w_ret_state == ST_DONE);
    assign out_addr_o      = w_ret_addr;
    assign out_data_o      = w_ret_data;
    assign outstanding_o   = r_outstanding;
    assign err_o           = r_err;

    // Entry state transitions; issue, response and retire always hit
    // entries in different states, so at most one applies per entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_IDS; i++) begin
                r_state[i] <= ST_FREE;
            end
        end else begin
            for (int i = 0; i < NUM_IDS; i++) begin
                if (w_fire && (w_alloc_ptr == ID_WIDTH'(i))) begin
                    r_state[i] <= ST_ISSUED;
                end
                if (w_resp_ok && (mem_resp_id_i == ID_WIDTH'(i))) begin
                    r_state[i] <= ST_DONE;
                end
                if (w_retire && (w_ret_ptr == ID_WIDTH'(i))) begin
                    r_state[i] <= ST_FREE;
                end
            end
        end
    end

    // Payload capture: address on issue, data on accepted response
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_IDS; i++) begin
            if (w_fire && (w_alloc_ptr == ID_WIDTH'(i))) begin
                r_addr[i] <= req_addr_i;
            end
            if (w_resp_ok && (mem_resp_id_i == ID_WIDTH'(i))) begin
                r_data[i] <= mem_resp_data_i;
            end
        end
    end

    // Outstanding count and sticky protocol error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            case ({w_fire, w_retire})
                2'b10:   r_outstanding <= r_outstanding + CNT_WIDTH'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_WIDTH'(1);
                default: r_outstanding <= r_outstanding;
            endcase
            if (w_resp_bad) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_consumer_txn_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_consumer_txn_tracker
//  Description : Self-checking bench for consumer_txn_tracker (16-entry and
//                5-entry instances) with an in-order completion scoreboard.
//  Revision    : 1.0 - initial
// ============================================================================
module tb_consumer_txn_tracker;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 16-entry instance
    logic        req_valid, req_ready, mem_req_valid, mem_req_ready;
    logic [63:0] req_addr, mem_req_addr;
    logic [3:0]  mem_req_id;
    logic        mem_resp_valid;
    logic [3:0]  mem_resp_id;
    logic [63:0] mem_resp_data;
    logic        out_valid, out_ready;
    logic [63:0] out_addr, out_data;
    logic [4:0]  outstanding;
    logic        err;

    // 5-entry instance
    logic        s5_req_valid, s5_req_ready, s5_mem_req_valid, s5_mem_req_ready;
    logic [63:0] s5_req_addr, s5_mem_req_addr;
    logic [3:0]  s5_mem_req_id;
    logic        s5_mem_resp_valid;
    logic [3:0]  s5_mem_resp_id;
    logic [63:0] s5_mem_resp_data;
    logic        s5_out_valid, s5_out_ready;
    logic [63:0] s5_out_addr, s5_out_data;
    logic [2:0]  s5_outstanding;
    logic        s5_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        sb_q[$];
    logic [63:0] id_addr [16];

    consumer_txn_tracker #(
        .ADDR_WIDTH (64), .DATA_WIDTH (64), .ID_WIDTH (4), .NUM_IDS (16)
    ) u_dut (
        .clk (clk), .rst_n (rst_n),
        .req_valid_i (req_valid), .req_ready_o (req_ready), .req_addr_i (req_addr),
        .mem_req_valid_o (mem_req_valid), .mem_req_ready_i (mem_req_ready),
        .mem_req_addr_o (mem_req_addr), .mem_req_id_o (mem_req_id),
        .mem_resp_valid_i (mem_resp_valid), .mem_resp_id_i (mem_resp_id),
        .mem_resp_data_i (mem_resp_data),
        .out_valid_o (out_valid), .out_ready_i (out_ready),
        .out_addr_o (out_addr), .out_data_o (out_data),
        .outstanding_o (outstanding), .err_o (err)
    );

    consumer_txn_tracker #(
        .ADDR_WIDTH (64), .DATA_WIDTH (64), .ID_WIDTH (4), .NUM_IDS (5)
    ) u_dut5 (
        .clk (clk), .rst_n (rst_n),
        .req_valid_i (s5_req_valid), .req_ready_o (s5_req_ready), .req_addr_i (s5_req_addr),
        .mem_req_valid_o (s5_mem_req_valid), .mem_req_ready_i (s5_mem_req_ready),
        .mem_req_addr_o (s5_mem_req_addr), .mem_req_id_o (s5_mem_req_id),
        .mem_resp_valid_i (s5_mem_resp_valid), .mem_resp_id_i (s5_mem_resp_id),
        .mem_resp_data_i (s5_mem_resp_data),
        .out_valid_o (s5_out_valid), .out_ready_i (s5_out_ready),
        .out_addr_o (s5_out_addr), .out_data_o (s5_out_data),
        .outstanding_o (s5_outstanding), .err_o (s5_err)
    );

    function automatic logic [63:0] data_of(input logic [63:0] a);
        return {a[31:0] ^ 32'hDEAD_BEEF, ~a[31:0]};
    endfunction

    task automatic idle_inputs();
        req_valid = 0; req_addr = '0; mem_req_ready = 0;
        mem_resp_valid = 0; mem_resp_id = '0; mem_resp_data = '0; out_ready = 0;
        s5_req_valid = 0; s5_req_addr = '0; s5_mem_req_ready = 0;
        s5_mem_resp_valid = 0; s5_mem_resp_id = '0; s5_mem_resp_data = '0; s5_out_ready = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        sb_q.delete();
    endtask

    // Issue one read on the 16-entry instance and queue its expected completion
    task automatic issue(input logic [63:0] a, output logic [3:0] id);
        int   n;
        exp_t e;
        req_addr = a; req_valid = 1; mem_req_ready = 1;
        #1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!req_ready) begin
            n_tests++; n_fail++;
            $display("FAIL issue_timeout: req_ready=%0b required 1", req_ready);
        end
        id = mem_req_id;
        id_addr[id] = a;
        e.addr = a; e.data = data_of(a);
        sb_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic resp(input logic [3:0] id, input logic [63:0] d);
        mem_resp_id = id; mem_resp_data = d; mem_resp_valid = 1;
        @(posedge clk); #1;
        mem_resp_valid = 0;
    endtask

    // Retire everything queued, comparing each completion with the scoreboard
    task automatic drain();
        int   n;
        exp_t e;
        out_ready = 1;
        #1;
        n = 0;
        while (sb_q.size() > 0 && n < 100) begin
            if (out_valid) begin
                e = sb_q.pop_front();
                n_tests++;
                if (out_addr !== e.addr || out_data !== e.data) begin
                    n_fail++;
                    $display("FAIL drain_order: addr=%h data=%h required addr=%h data=%h",
                             out_addr, out_data, e.addr, e.data);
                end
            end
            @(posedge clk); #1; n++;
        end
        if (sb_q.size() > 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: %0d left, required 0", sb_q.size());
        end
        out_ready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        req_valid = 1; mem_req_ready = 1; s5_req_valid = 1; s5_mem_req_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (outstanding !== 5'd0 || err !== 1'b0 || out_valid !== 1'b0 ||
            req_ready !== 1'b0 || mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state16: outst=%0d err=%b ov=%b rr=%b mv=%b required 0 0 0 0 0",
                     outstanding, err, out_valid, req_ready, mem_req_valid);
        end
        n_tests++;
        if (s5_outstanding !== 3'd0 || s5_err !== 1'b0 || s5_out_valid !== 1'b0 ||
            s5_req_ready !== 1'b0 || s5_mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state5: outst=%0d err=%b ov=%b rr=%b mv=%b required 0 0 0 0 0",
                     s5_outstanding, s5_err, s5_out_valid, s5_req_ready, s5_mem_req_valid);
        end
        req_valid = 0; s5_req_valid = 0;
        rst_n = 1;
        #1;
        n_tests++;
        if (req_ready !== 1'b1 || mem_req_id !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_release: rr=%b id=%0d required 1 0", req_ready, mem_req_id);
        end
        idle_inputs();
    endtask

    task automatic test_out_of_order();
        logic [3:0] i0, i1, i2;
        apply_reset();
        issue(64'h100, i0);
        issue(64'h108, i1);
        issue(64'h110, i2);
        n_tests++;
        if ({i0, i1, i2} !== 12'h012) begin
            n_fail++;
            $display("FAIL ooo_ids: %0d %0d %0d required 0 1 2", i0, i1, i2);
        end
        resp(4'd2, data_of(64'h110));
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ooo_hold: out_valid=%b required 0", out_valid);
        end
        resp(4'd0, data_of(64'h100));
        n_tests++;
        if (out_valid !== 1'b1 || out_addr !== 64'h100) begin
            n_fail++;
            $display("FAIL ooo_first_latency: ov=%b addr=%h required 1 100", out_valid, out_addr);
        end
        resp(4'd1, data_of(64'h108));
        drain();
        n_tests++;
        if (err !== 1'b0 || outstanding !== 5'd0) begin
            n_fail++;
            $display("FAIL ooo_final: err=%b outst=%0d required 0 0", err, outstanding);
        end
    endtask

    task automatic test_full_wrap();
        logic [3:0] id;
        exp_t       e;
        apply_reset();
        for (int i = 0; i < 16; i++) issue(64'h1000 + 64'(i * 8), id);
        req_valid = 1; mem_req_ready = 1;
        #1;
        n_tests++;
        if (outstanding !== 5'd16 || req_ready !== 1'b0 || mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_backpressure: outst=%0d rr=%b mv=%b required 16 0 0",
                     outstanding, req_ready, mem_req_valid);
        end
        req_valid = 0;
        resp(4'd0, data_of(id_addr[0]));
        e = sb_q.pop_front();
        n_tests++;
        if (out_valid !== 1'b1 || out_addr !== e.addr || out_data !== e.data) begin
            n_fail++;
            $display("FAIL full_retire0: ov=%b addr=%h data=%h required 1 %h %h",
                     out_valid, out_addr, out_data, e.addr, e.data);
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        #1;
        n_tests++;
        if (req_ready !== 1'b1 || mem_req_id !== 4'd0 || outstanding !== 5'd15) begin
            n_fail++;
            $display("FAIL full_wrap_realloc: rr=%b id=%0d outst=%0d required 1 0 15",
                     req_ready, mem_req_id, outstanding);
        end
        for (int i = 1; i < 16; i++) resp(4'(i), data_of(id_addr[i]));
        drain();
    endtask

    task automatic test_nonpow2();
        logic [63:0] a;
        logic [3:0]  got;
        int          n;
        apply_reset();
        s5_out_ready = 1;
        s5_mem_req_ready = 1;
        for (int k = 0; k < 7; k++) begin
            a = 64'h2000 + 64'(k * 8);
            s5_req_addr = a; s5_req_valid = 1;
            #1;
            n = 0;
            while (!s5_req_ready && n < 20) begin
                @(posedge clk); #1; n++;
            end
            got = s5_mem_req_id;
            n_tests++;
            if (!s5_req_ready || got !== 4'(k % 5)) begin
                n_fail++;
                $display("FAIL n5_id_seq[%0d]: rr=%b id=%0d required 1 %0d", k, s5_req_ready, got, k % 5);
            end
            @(posedge clk); #1;
            s5_req_valid = 0;
            s5_mem_resp_id = got; s5_mem_resp_data = data_of(a); s5_mem_resp_valid = 1;
            @(posedge clk); #1;
            s5_mem_resp_valid = 0;
            n_tests++;
            if (s5_out_valid !== 1'b1 || s5_out_addr !== a || s5_out_data !== data_of(a)) begin
                n_fail++;
                $display("FAIL n5_complete[%0d]: ov=%b addr=%h data=%h required 1 %h %h",
                         k, s5_out_valid, s5_out_addr, s5_out_data, a, data_of(a));
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (s5_err !== 1'b0 || s5_outstanding !== 3'd0) begin
            n_fail++;
            $display("FAIL n5_pre_err: err=%b outst=%0d required 0 0", s5_err, s5_outstanding);
        end
        s5_mem_resp_id = 4'd6; s5_mem_resp_data = 64'hFFFF; s5_mem_resp_valid = 1;
        @(posedge clk); #1;
        s5_mem_resp_valid = 0;
        n_tests++;
        if (s5_err !== 1'b1 || s5_outstanding !== 3'd0 || s5_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL n5_range_err: err=%b outst=%0d ov=%b required 1 0 0",
                     s5_err, s5_outstanding, s5_out_valid);
        end
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        logic [3:0] id;
        exp_t       e;
        apply_reset();
        issue(64'h3000, id);
        issue(64'h3008, id);
        issue(64'h3010, id);
        resp(4'd0, data_of(64'h3000));
        e = sb_q.pop_front();
        n_tests++;
        if (outstanding !== 5'd3 || out_valid !== 1'b1 || out_addr !== e.addr) begin
            n_fail++;
            $display("FAIL simul_setup: outst=%0d ov=%b addr=%h required 3 1 %h",
                     outstanding, out_valid, out_addr, e.addr);
        end
        req_addr = 64'h3018; req_valid = 1; mem_req_ready = 1;
        mem_resp_id = 4'd1; mem_resp_data = data_of(64'h3008); mem_resp_valid = 1;
        out_ready = 1;
        #1;
        n_tests++;
        if (req_ready !== 1'b1 || mem_req_id !== 4'd3) begin
            n_fail++;
            $display("FAIL simul_issue: rr=%b id=%0d required 1 3", req_ready, mem_req_id);
        end
        id_addr[3] = 64'h3018;
        e.addr = 64'h3018; e.data = data_of(64'h3018);
        sb_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 0; mem_resp_valid = 0; out_ready = 0;
        #1;
        n_tests++;
        if (outstanding !== 5'd3 || mem_req_id !== 4'd4 || out_valid !== 1'b1 ||
            out_addr !== 64'h3008 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_result: outst=%0d id=%0d ov=%b addr=%h err=%b required 3 4 1 3008 0",
                     outstanding, mem_req_id, out_valid, out_addr, err);
        end
        resp(4'd2, data_of(64'h3010));
        resp(4'd3, data_of(64'h3018));
        drain();
    endtask

    task automatic test_dup_err();
        logic [3:0] id;
        apply_reset();
        issue(64'h4000, id);
        issue(64'h4008, id);
        issue(64'h4010, id);
        resp(4'd2, data_of(64'h4010));
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL dup_pre: err=%b required 0", err);
        end
        resp(4'd2, 64'hBAD0_BAD0_BAD0_BAD0);
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL dup_done_err: err=%b required 1", err);
        end
        resp(4'd0, data_of(64'h4000));
        resp(4'd1, data_of(64'h4008));
        drain();
        apply_reset();
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL dup_err_cleared: err=%b required 0", err);
        end
        resp(4'd9, 64'h1234);
        n_tests++;
        if (err !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL free_resp_err: err=%b ov=%b required 1 0", err, out_valid);
        end
    endtask

    task automatic test_reset_midflight();
        logic [3:0] id;
        int         bad;
        apply_reset();
        for (int i = 0; i < 4; i++) issue(64'h5000 + 64'(i * 8), id);
        n_tests++;
        if (outstanding !== 5'd4) begin
            n_fail++;
            $display("FAIL mid_pre: outst=%0d required 4", outstanding);
        end
        rst_n = 0;
        req_valid = 1; mem_req_ready = 1;
        #1;
        n_tests++;
        if (req_ready !== 1'b0 || mem_req_valid !== 1'b0 || outstanding !== 5'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_in_reset: rr=%b mv=%b outst=%0d ov=%b required 0 0 0 0",
                     req_ready, mem_req_valid, outstanding, out_valid);
        end
        @(posedge clk); #1;
        req_valid = 0;
        rst_n = 1;
        sb_q.delete();
        out_ready = 1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            resp(4'(i), data_of(id_addr[i]));
            if (out_valid !== 1'b0) bad++;
        end
        out_ready = 0;
        n_tests++;
        if (bad != 0 || err !== 1'b1 || outstanding !== 5'd0) begin
            n_fail++;
            $display("FAIL mid_stale_resp: ov_hits=%0d err=%b outst=%0d required 0 1 0",
                     bad, err, outstanding);
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_out_of_order();
        test_full_wrap();
        test_nonpow2();
        test_simultaneous();
        test_dup_err();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: sim time exceeded, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/consumer_txn_tracker.md
Name: consumer_txn_tracker

Overview:
Tracks outstanding consumer-side memory read transactions for the cohort consumer queue path. Allocates a transaction ID per outgoing read, stores the read address, and accepts responses returned out of order by ID. Delivers completed data strictly in request order. Sits between the consumer fifo control logic and the tile memory interface, generalising the fixed 64-bit address / 4-bit ID transaction types to configurable width and depth.

Parameters:
ADDR_WIDTH, 64, request address width
DATA_WIDTH, 64, response data width
ID_WIDTH, 4, transaction ID width
NUM_IDS, 16, tracker entries; legal range 2..2**ID_WIDTH; need not be a power of 2
CNT_WIDTH, $clog2(NUM_IDS+1), width of outstanding count (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid_i  in  1  consumer read request valid
req_ready_o  out  1  request accepted this cycle when high with req_valid_i
req_addr_i  in  ADDR_WIDTH  read address
mem_req_valid_o  out  1  read issued to memory
mem_req_ready_i  in  1  memory accepts read
mem_req_addr_o  out  ADDR_WIDTH  issued address (= req_addr_i)
mem_req_id_o  out  ID_WIDTH  allocated transaction ID
mem_resp_valid_i  in  1  response valid (always accepted)
mem_resp_id_i  in  ID_WIDTH  response transaction ID
mem_resp_data_i  in  DATA_WIDTH  response data
out_valid_o  out  1  in-order completed data valid
out_ready_i  in  1  downstream accepts completion
out_addr_o  out  ADDR_WIDTH  address of completing transaction
out_data_o  out  DATA_WIDTH  data of completing transaction
outstanding_o  out  CNT_WIDTH  entries not FREE
err_o  out  1  sticky protocol error

Behaviour:
- Entry array [NUM_IDS]: state {FREE, ISSUED, DONE}, addr, data. Allocation pointer alloc_ptr, retire pointer ret_ptr, both wrap NUM_IDS-1 -> 0.
- Reset (async, rst_n low): all entries FREE, alloc_ptr = ret_ptr = 0, outstanding_o = 0, err_o = 0, out_valid_o = 0, req_ready_o = 0, mem_req_valid_o = 0. Entry addr/data need no reset. Reset mid-operation drops all in-flight transactions; later responses carrying stale IDs arrive at FREE entries and set err_o.
- Issue (combinational pass-through): slot_free = (state[alloc_ptr] == FREE). mem_req_valid_o = req_valid_i & slot_free. req_ready_o = mem_req_ready_i & slot_free. mem_req_id_o = alloc_ptr.
- On fire (req_valid_i & req_ready_o): entry <- ISSUED, addr captured, alloc_ptr advances. No combinational path from mem_req_ready_i to mem_req_valid_o.
- Full: all entries non-FREE, so slot_free = 0 and req_ready_o = 0. Back-pressure holds until a retire frees state[alloc_ptr].
- Response: if state[mem_resp_id_i] == ISSUED, store data and set the entry DONE at the next edge. If the state is FREE or DONE, or mem_resp_id_i >= NUM_IDS, drop the response and set err_o (sticky until reset).
- Retire: out_valid_o = (state[ret_ptr] == DONE), driven from registered state. out_addr_o / out_data_o come from entry[ret_ptr]. On out_valid_o & out_ready_i: entry <- FREE, ret_ptr advances.
- Minimum latency: response accepted at edge t gives out_valid_o high in cycle t+1. A freed entry is allocatable in the cycle after retirement.
- Simultaneous events: issue, response and retire may all occur in one cycle on distinct entries. Issue targets FREE, response targets ISSUED, retire targets DONE, so they never collide. A response to an ID being issued that same cycle is an error (entry is still FREE).
- outstanding_o += fire, -= retire. Both in the same cycle leaves it unchanged. Range 0..NUM_IDS.

Decomposition:
- Extend consumer_transaction_pkg with parametrised addr/id/data widths, the entry-state enum (FREE/ISSUED/DONE), and the entry struct typedef. Keep existing addr_t/id_t as the default 64/4 instances.
- One sub-module: consumer_txn_ptr, a wrapping index counter with increment enable and a NUM_IDS modulus. Instantiate it twice (alloc, retire).

Test Plan:
- Reset, then 3 reads at addr 0x100/0x108/0x110 with responses returned in ID order 2,0,1 -> outputs appear in order 0x100,0x108,0x110 with matching data; first out_valid_o one cycle after ID0's response.
- Issue 16 reads with NUM_IDS=16 and no responses -> outstanding_o=16, req_ready_o=0. Respond and retire ID0 -> req_ready_o=1 the next cycle, mem_req_id_o=0 (wrap).
- NUM_IDS=5 with ID_WIDTH=4: issue 7 transactions with steady retire -> IDs sequence 0,1,2,3,4,0,1. Response with ID 6 -> err_o=1, state unchanged.
- Same cycle: issue into ID3, response for ID1, retire ID0 -> all three take effect, outstanding_o unchanged.
- Duplicate response for a DONE ID2 -> err_o=1, original data retained. Response to a FREE ID -> err_o=1.
- Assert rst_n with 4 outstanding, then release and send the old responses -> out_valid_o stays 0, err_o=1, outstanding_o=0.
